i2s_receiver: RTL and testbench

- Serial-to-parallel I2S receiver, the capture end of the I2S link driven by the team's I2S transmitter.
- Inputs are external serial lines: `bit_clk`, `frame_clk` and `data`, e.g. from an ADC/codec, or looped back from the transmitter for test.
- The block oversamples these lines on the system clock and outputs complete stereo sample pairs with a one-cycle valid strobe, for the synth datapath or the seven-segment/debug logic.

---
 rtl/i2s_receiver.sv | 112 +++++++++++
 tb/tb_i2s_receiver.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/i2s_receiver.sv
// I2S capture: oversamples bit_clk/frame_clk/data on clk and assembles
// stereo words, one-bit-delayed Philips framing, MSB first.
module i2s_receiver #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int CNT_WIDTH    = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    bit_clk,
  input  logic                    frame_clk,
  input  logic                    data,
  output logic [SAMPLE_WIDTH-1:0] sample_left,
  output logic [SAMPLE_WIDTH-1:0] sample_right,
  output logic                    sample_valid,
  output logic                    frame_error,
  output logic                    locked
);

  typedef enum logic {HUNT, RUN} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] WORD_LEN = CNT_WIDTH'(SAMPLE_WIDTH);

  state_t state_q, state_d;

  logic bclk_s1, bclk_s2, bclk_s3;
  logic ws_s1, ws_s2;
  logic d_s1, d_s2;
  logic ws_prev;

  logic [SAMPLE_WIDTH-1:0] shift_q, shift_ins;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_inc;
  logic                    bclk_rise, ws_edge, word_done;

  always_comb begin
    bclk_rise = bclk_s2 & ~bclk_s3;
    ws_edge   = bclk_rise && (ws_s2 != ws_prev);
    word_done = (state_q == RUN) && ws_edge;

    state_d = state_q;
    if (state_q == HUNT && ws_edge) state_d = RUN;

    // Bit k of a word lands at SAMPLE_WIDTH-1-k; bits past the buffer are dropped.
    shift_ins = shift_q;
    for (int i = 0; i < SAMPLE_WIDTH; i++) begin
      if (int'(cnt_q) == SAMPLE_WIDTH - 1 - i) shift_ins[i] = d_s2;
    end

    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= HUNT;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_s1      <= 1'b0;
      bclk_s2      <= 1'b0;
      bclk_s3      <= 1'b0;
      ws_s1        <= 1'b0;
      ws_s2        <= 1'b0;
      d_s1         <= 1'b0;
      d_s2         <= 1'b0;
      ws_prev      <= 1'b0;
      shift_q      <= '0;
      cnt_q        <= '0;
      sample_left  <= '0;
      sample_right <= '0;
      sample_valid <= 1'b0;
      frame_error  <= 1'b0;
      locked       <= 1'b0;
    end else begin
      bclk_s1      <= bit_clk;
      bclk_s2      <= bclk_s1;
      bclk_s3      <= bclk_s2;
      ws_s1        <= frame_clk;
      ws_s2        <= ws_s1;
      d_s1         <= data;
      d_s2         <= d_s1;
      sample_valid <= 1'b0;
      frame_error  <= 1'b0;

      if (bclk_rise) begin
        ws_prev <= ws_s2;
        if (state_q == HUNT) begin
          if (ws_edge) begin
            shift_q <= '0;
            cnt_q   <= '0;
            locked  <= 1'b1;
          end
        end else if (word_done) begin
          // Boundary bit belongs to the channel that just ended (ws_prev).
          if (ws_prev) begin
            sample_right <= shift_ins;
            sample_valid <= 1'b1;
          end else begin
            sample_left  <= shift_ins;
          end
          frame_error <= (cnt_inc != WORD_LEN);
          shift_q     <= '0;
          cnt_q       <= '0;
        end else begin
          shift_q <= shift_ins;
          cnt_q   <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: table of word formats plus hand-written
// reset, held-clock and mid-frame-start sequences.
module tb_i2s_receiver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bit_clk = 1'b0;
  logic        frame_clk = 1'b0;
  logic        data = 1'b0;
  logic [15:0] sample_left, sample_right;
  logic        sample_valid, frame_error, locked;

  i2s_receiver #(.SAMPLE_WIDTH(16), .CNT_WIDTH(6)) dut (
    .clk(clk), .reset(reset), .bit_clk(bit_clk), .frame_clk(frame_clk),
    .data(data), .sample_left(sample_left), .sample_right(sample_right),
    .sample_valid(sample_valid), .frame_error(frame_error), .locked(locked)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_prelock = 0;
  logic [15:0] got_l_q[$];
  logic [15:0] got_r_q[$];

  always @(negedge clk) begin
    if (sample_valid) begin
      n_valid++;
      got_l_q.push_back(sample_left);
      got_r_q.push_back(sample_right);
    end
    if (frame_error) n_err++;
    if (!locked && (sample_valid || frame_error)) n_prelock++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; bit_clk = 1'b0; frame_clk = 1'b0; data = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // One bit slot: bit_clk low 4 clk (lines change), high 4 clk.
  task automatic send_bit(input logic ws, input logic d);
    @(negedge clk);
    bit_clk = 1'b0; frame_clk = ws; data = d;
    repeat (3) @(negedge clk);
    bit_clk = 1'b1;
    repeat (4) @(negedge clk);
    bit_clk = 1'b0;
  endtask

  // Word for channel c; ws flips on its last bit (one-bit delay framing).
  task automatic send_word(input logic c, input logic [23:0] w, input int n);
    for (int k = 0; k < n; k++) send_bit((k == n - 1) ? ~c : c, w[n - 1 - k]);
  endtask

  typedef struct {
    int          width;
    logic [23:0] l;
    logic [23:0] r;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
    int          exp_err;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int bv, be;
    logic [15:0] w;
    vecs[0] = '{16, 24'h00A5C3, 24'h001234, 16'hA5C3, 16'h1234, 0};
    vecs[1] = '{8,  24'h00009F, 24'h000001, 16'h9F00, 16'h0100, 5};
    vecs[2] = '{24, 24'h123456, 24'hFEDCBA, 16'h1234, 16'hFEDC, 5};
    vecs[3] = '{16, 24'h00FFFF, 24'h000001, 16'hFFFF, 16'h0001, 0};

    do_reset();
    @(negedge clk);
    check("reset_left", sample_left, 16'h0);
    check("reset_right", sample_right, 16'h0);
    check("reset_locked", locked, 1'b0);

    // First left word is discarded while hunting; 3 frames -> 3 pairs.
    foreach (vecs[i]) begin
      do_reset();
      bv = n_valid; be = n_err;
      for (int f = 0; f < 3; f++) begin
        send_word(1'b0, vecs[i].l, vecs[i].width);
        send_word(1'b1, vecs[i].r, vecs[i].width);
      end
      repeat (4) @(negedge clk);
      check($sformatf("v%0d_valid_cnt", i), n_valid - bv, 3);
      check($sformatf("v%0d_err_cnt", i), n_err - be, vecs[i].exp_err);
      check($sformatf("v%0d_first_left", i), got_l_q[bv], 16'h0);
      check($sformatf("v%0d_left", i), sample_left, vecs[i].exp_l);
      check($sformatf("v%0d_right", i), sample_right, vecs[i].exp_r);
      check($sformatf("v%0d_locked", i), locked, 1'b1);
    end

    // Reset asserted during bit 7 of a left word.
    do_reset();
    send_word(1'b0, 24'h1111, 16);
    send_word(1'b1, 24'h2222, 16);
    check("pre_rst_right", sample_right, 16'h2222);
    w = 16'h5A5A;
    for (int k = 0; k < 7; k++) send_bit(1'b0, w[15 - k]);
    @(negedge clk);
    bit_clk = 1'b0; frame_clk = 1'b0; data = w[8];
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_left", sample_left, 16'h0);
    check("rst_mid_right", sample_right, 16'h0);
    check("rst_mid_locked", locked, 1'b0);
    check("rst_mid_pulses", {sample_valid, frame_error}, 2'b00);
    bv = n_valid;
    repeat (2) @(negedge clk);
    bit_clk = 1'b1;
    repeat (4) @(negedge clk);
    for (int k = 8; k < 16; k++) send_bit((k == 15) ? 1'b1 : 1'b0, w[15 - k]);
    check("relock", locked, 1'b1);
    check("relock_no_valid", n_valid - bv, 0);
    send_word(1'b1, 24'h3C3C, 16);
    send_word(1'b0, 24'h5A5A, 16);
    send_word(1'b1, 24'h3C3C, 16);
    repeat (4) @(negedge clk);
    check("relock_valid_cnt", n_valid - bv, 2);
    check("relock_first_left", got_l_q[bv], 16'h0);
    check("relock_left", sample_left, 16'h5A5A);
    check("relock_right", sample_right, 16'h3C3C);

    // bit_clk stopped for 1000 clk: nothing moves.
    bv = n_valid; be = n_err;
    repeat (1000) @(negedge clk);
    check("hold_valid", n_valid - bv, 0);
    check("hold_err", n_err - be, 0);
    check("hold_left", sample_left, 16'h5A5A);
    check("hold_right", sample_right, 16'h3C3C);
    send_word(1'b0, 24'h0F0F, 16);
    send_word(1'b1, 24'hF0F0, 16);
    repeat (4) @(negedge clk);
    check("resume_valid", n_valid - bv, 1);
    check("resume_left", sample_left, 16'h0F0F);
    check("resume_right", sample_right, 16'hF0F0);
    check("resume_err", n_err - be, 0);

    // Stream picked up in the middle of a right word.
    do_reset();
    w = 16'hBEEF;
    for (int k = 11; k < 16; k++) send_bit((k == 15) ? 1'b0 : 1'b1, w[15 - k]);
    for (int f = 0; f < 2; f++) begin
      send_word(1'b0, 24'hCAFE, 16);
      send_word(1'b1, 24'hBEEF, 16);
    end
    repeat (4) @(negedge clk);
    check("mid_locked", locked, 1'b1);
    check("mid_left", sample_left, 16'hCAFE);
    check("mid_right", sample_right, 16'hBEEF);
    check("mid_last_left", got_l_q[got_l_q.size() - 1], 16'hCAFE);
    check("no_prelock_pulse", n_prelock, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
